// File: rtl/align_mant.sv
//------------------------------------------------------------------------------
// align_mant
//   Mantissa-alignment stage of the single-precision floating-point adder.
//   It restores the hidden bits and appends guard/round/sticky positions. The
//   smaller-exponent significand is right-shifted by the exponent difference in
//   two registered steps: a coarse shift by 8*dif[4:3], then a fine shift by
//   dif[2:0]. A difference of 27 or more flushes the value to zero.
//
//   Flow control uses one global enable, en = !out_valid | out_ready. Every
//   stage register loads or holds together. Bubbles are not collapsed.
//
//   Optional feature macro: ALIGN_STICKY_EN
//     defined     : the bits shifted out are OR-reduced into mant_small_o[0]
//     not defined : no sticky logic; mant_small_o is the plain truncated shift
//
// Ports
//   clk_i          rising-edge clock
//   clr_i          asynchronous active-low reset (clears valids and data)
//   in_valid_i     input beat present
//   in_ready_o     stage accepts a beat this cycle
//   big_i[31:0]    operand with the larger (or equal) exponent
//   small_i[31:0]  operand with the smaller exponent
//   dif_i[7:0]     unsigned exponent difference big.exp - small.exp
//   out_valid_o    output beat present
//   out_ready_i    downstream accepts the beat
//   exp_out_o[7:0] common exponent (big_i[30:23])
//   sign_big_o     big_i[31]
//   sign_small_o   small_i[31]
//   mant_big_o     {hidden, big frac, 3'b000}
//   mant_small_o   aligned {hidden, small frac, G, R, S}
//------------------------------------------------------------------------------
module align_mant (
   input  logic        clk_i,
   input  logic        clr_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] big_i,
   input  logic [31:0] small_i,
   input  logic [7:0]  dif_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [7:0]  exp_out_o,
   output logic        sign_big_o,
   output logic        sign_small_o,
   output logic [26:0] mant_big_o,
   output logic [26:0] mant_small_o
);

   localparam logic [26:0] ONES = '1;

   logic        en;

   // input-side significands
   logic [26:0] sig_big;
   logic [26:0] sig_small;
   logic        flush;       // dif >= 27: everything is shifted out
   logic [4:0]  coarse_sh;

   // stage A
   logic        va_q;
   logic [26:0] a_d,        a_q;
   logic [2:0]  fine_d,     fine_q;
   logic [7:0]  exp_a_q;
   logic        sb_a_q;
   logic        ss_a_q;
   logic [26:0] mb_a_q;

   // stage B (output registers)
   logic        vb_q;
   logic [26:0] b_shift;
   logic        sticky_b;
   logic [26:0] ms_d,       ms_q;
   logic [7:0]  exp_q;
   logic        sb_q;
   logic        ss_q;
   logic [26:0] mb_q;

   assign en         = !vb_q | out_ready_i;
   assign in_ready_o = en;

   //---------------------------------------------------------------------------
   // Stage A: hidden bit restore and coarse shift
   //---------------------------------------------------------------------------
   always_comb begin
      sig_big   = {(|big_i[30:23]),   big_i[22:0],   3'b000};
      sig_small = {(|small_i[30:23]), small_i[22:0], 3'b000};
      flush     = (dif_i >= 8'd27);
      coarse_sh = {dif_i[4:3], 3'b000};
      a_d       = '0;
      fine_d    = '0;
      if (!flush) begin
         a_d    = sig_small >> coarse_sh;
         fine_d = dif_i[2:0];
      end
   end

   always_ff @(posedge clk_i or negedge clr_i) begin
      if (!clr_i) begin
         va_q    <= 1'b0;
         a_q     <= '0;
         fine_q  <= '0;
         exp_a_q <= '0;
         sb_a_q  <= 1'b0;
         ss_a_q  <= 1'b0;
         mb_a_q  <= '0;
      end else if (en) begin
         va_q <= in_valid_i;
         if (in_valid_i) begin
            a_q     <= a_d;
            fine_q  <= fine_d;
            exp_a_q <= big_i[30:23];
            sb_a_q  <= big_i[31];
            ss_a_q  <= small_i[31];
            mb_a_q  <= sig_big;
         end
      end
   end

`ifdef ALIGN_STICKY_EN
   logic sticky_a_d, sticky_a_q;

   // On a flush the whole significand is lost, so the sticky is its OR.
   always_comb begin
      sticky_a_d = |(sig_small & ~(ONES << coarse_sh));
      if (flush) begin
         sticky_a_d = |sig_small;
      end
   end

   always_ff @(posedge clk_i or negedge clr_i) begin
      if (!clr_i) begin
         sticky_a_q <= 1'b0;
      end else if (en && in_valid_i) begin
         sticky_a_q <= sticky_a_d;
      end
   end

   assign sticky_b = sticky_a_q | (|(a_q & ~(ONES << fine_q)));
`else
   assign sticky_b = 1'b0;
`endif

   //---------------------------------------------------------------------------
   // Stage B: fine shift and sticky merge
   //   A flushed beat carries fine_q = 0 and a_q = 0, so skipping the fine
   //   shift needs no extra select.
   //---------------------------------------------------------------------------
   always_comb begin
      b_shift = a_q >> fine_q;
      ms_d    = {b_shift[26:1], b_shift[0] | sticky_b};
   end

   always_ff @(posedge clk_i or negedge clr_i) begin
      if (!clr_i) begin
         vb_q  <= 1'b0;
         ms_q  <= '0;
         exp_q <= '0;
         sb_q  <= 1'b0;
         ss_q  <= 1'b0;
         mb_q  <= '0;
      end else if (en) begin
         vb_q <= va_q;
         if (va_q) begin
            ms_q  <= ms_d;
            exp_q <= exp_a_q;
            sb_q  <= sb_a_q;
            ss_q  <= ss_a_q;
            mb_q  <= mb_a_q;
         end
      end
   end

   assign out_valid_o  = vb_q;
   assign exp_out_o    = exp_q;
   assign sign_big_o   = sb_q;
   assign sign_small_o = ss_q;
   assign mant_big_o   = mb_q;
   assign mant_small_o = ms_q;

endmodule
